// File: rtl/wb_spi_master_ctrl.sv
// Wishbone classic slave that runs a single-frame, mode-0 (CPOL=0) SPI master.
// SCLK is derived from CLK_I by a programmable half-period counter.
module wb_spi_master_ctrl #(
    parameter int               DATA_W  = 8,
    parameter int               DIV_W   = 8,
    parameter logic [DIV_W-1:0] DIV_RST = 8'd3
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [7:0]  ADR_I,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    output logic        ACK_O,
    output logic        IRQ_O,
    output logic        SCLK_O,
    output logic        MOSI_O,
    input  logic        MISO_I,
    output logic        SS_N_O
);
    localparam int                HALF_W    = $clog2(2 * DATA_W);
    localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'(2 * DATA_W - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_DONE} state_t;

    state_t            r_state, w_next;
    logic              r_ack;
    logic [31:0]       r_dat;
    logic              r_ie, r_done, r_ovr, r_busy, r_sclk;
    logic [DIV_W-1:0]  r_div, r_div_lat, r_cnt;
    logic [DATA_W-1:0] r_txdata, r_rxdata, r_tx_sh, r_rx_sh;
    logic [HALF_W-1:0] r_half;

    logic        w_req, w_wr, w_rd, w_ctrl_wr, w_div_wr, w_tx_wr, w_rx_rd;
    logic        w_start, w_tick, w_active, w_unused;
    logic [1:0]  w_adr;
    logic [31:0] w_rdata;

    assign w_adr     = ADR_I[3:2];
    assign w_req     = CYC_I & STB_I & ~r_ack;
    assign w_wr      = w_req & WE_I;
    assign w_rd      = w_req & ~WE_I;
    assign w_ctrl_wr = w_wr && (w_adr == 2'd0);
    assign w_div_wr  = w_wr && (w_adr == 2'd1);
    assign w_tx_wr   = w_wr && (w_adr == 2'd2);
    assign w_rx_rd   = w_rd && (w_adr == 2'd3);
    assign w_start   = w_tx_wr & ~r_busy;
    assign w_tick    = (r_cnt == '0);
    assign w_active  = (r_state == S_SETUP) || (r_state == S_SHIFT) || (r_state == S_HOLD);
    assign w_unused  = ^{ADR_I[7:4], ADR_I[1:0], DAT_I};

    always_comb begin
        w_rdata = '0;
        case (w_adr)
            2'd0:    w_rdata = {23'b0, r_ie, 5'b0, r_ovr, r_done, r_busy};
            2'd1:    w_rdata = 32'(r_div);
            2'd2:    w_rdata = 32'(r_txdata);
            default: w_rdata = 32'(r_rxdata);
        endcase
    end

    // NOTE: every state register uses <= so all flops sample pre-edge values together.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= CYC_I & STB_I & ~r_ack;
            r_dat <= w_rd ? w_rdata : '0;
        end
    end

    // Set events win over software clears landing on the same edge.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_ie     <= 1'b0;
            r_div    <= DIV_RST;
            r_txdata <= '0;
            r_rxdata <= '0;
            r_done   <= 1'b0;
            r_ovr    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            if (w_ctrl_wr) r_ie     <= DAT_I[0];
            if (w_div_wr)  r_div    <= DAT_I[DIV_W-1:0];
            if (w_tx_wr)   r_txdata <= DAT_I[DATA_W-1:0];
            if (r_state == S_DONE)                      r_done <= 1'b1;
            else if ((w_ctrl_wr && DAT_I[1]) || w_rx_rd) r_done <= 1'b0;
            if (w_tx_wr && r_busy)           r_ovr <= 1'b1;
            else if (w_ctrl_wr && DAT_I[2])  r_ovr <= 1'b0;
            if (w_start)                 r_busy <= 1'b1;
            else if (r_state == S_DONE)  r_busy <= 1'b0;
            if (r_state == S_DONE) r_rxdata <= r_rx_sh;
        end
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: default assigned first so no path through this block infers a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_SETUP;
            S_SETUP: if (w_tick) w_next = S_SHIFT;
            S_SHIFT: if (w_tick && (r_half == LAST_HALF)) w_next = S_HOLD;
            S_HOLD:  if (w_tick) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Divisor is latched at start so mid-transfer DIV writes only affect the next frame.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_div_lat <= '0;
            r_cnt     <= '0;
            r_tx_sh   <= '0;
            r_rx_sh   <= '0;
            r_half    <= '0;
            r_sclk    <= 1'b0;
        end else if (w_start) begin
            r_div_lat <= r_div;
            r_cnt     <= r_div;
            r_tx_sh   <= DAT_I[DATA_W-1:0];
            r_rx_sh   <= '0;
            r_half    <= '0;
            r_sclk    <= 1'b0;
        end else if (w_active) begin
            r_cnt <= w_tick ? r_div_lat : r_cnt - 1'b1;
            if (w_tick) begin
                if ((r_state == S_SETUP) || ((r_state == S_SHIFT) && (r_half != LAST_HALF))) begin
                    r_sclk <= ~r_sclk;
                    if (!r_sclk) r_rx_sh <= {r_rx_sh[DATA_W-2:0], MISO_I};
                    else         r_tx_sh <= {r_tx_sh[DATA_W-2:0], 1'b0};
                end else begin
                    r_sclk <= 1'b0;
                end
                if (r_state == S_SHIFT) r_half <= r_half + 1'b1;
            end
        end
    end

    assign ACK_O  = r_ack;
    assign DAT_O  = r_dat;
    assign IRQ_O  = r_done & r_ie;
    assign SCLK_O = r_sclk;
    assign SS_N_O = ~w_active;
    assign MOSI_O = w_active & r_tx_sh[DATA_W-1];

endmodule

// File: tb/tb_wb_spi_master_ctrl.sv
// Directed bench for wb_spi_master_ctrl: bus access, frame timing, overrun and reset.
module tb_wb_spi_master_ctrl;
    logic        clk, rst_n, cyc, stb, we, ack, irq, sclk, mosi, miso, ss_n;
    logic [7:0]  adr;
    logic [31:0] dat_w, dat_r;
    logic        loop_en, miso_val;

    int n_cmp = 0;
    int n_err = 0;

    int          mon_cyc = 0, mon_ss_low = 0, mon_rises = 0, mon_period = 0, mon_last_rise = 0;
    logic [31:0] mon_bits = '0;
    logic        mon_sclk_q = 1'b0;

    assign miso = loop_en ? mosi : miso_val;

    wb_spi_master_ctrl dut (
        .CLK_I(clk), .RST_I(rst_n), .ADR_I(adr), .CYC_I(cyc), .STB_I(stb), .WE_I(we),
        .DAT_I(dat_w), .DAT_O(dat_r), .ACK_O(ack), .IRQ_O(irq),
        .SCLK_O(sclk), .MOSI_O(mosi), .MISO_I(miso), .SS_N_O(ss_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mid-cycle observer of the SPI pins.
    always @(negedge clk) begin
        mon_cyc <= mon_cyc + 1;
        if (!ss_n) mon_ss_low <= mon_ss_low + 1;
        if (sclk && !mon_sclk_q) begin
            mon_rises     <= mon_rises + 1;
            mon_bits      <= {mon_bits[30:0], mosi};
            mon_period    <= mon_cyc - mon_last_rise;
            mon_last_rise <= mon_cyc;
        end
        mon_sclk_q <= sclk;
    end

    task automatic wb_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        while (ack) @(negedge clk);
        adr = a; dat_w = d; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ack) break;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [7:0] a, output logic [31:0] d, output int lat);
        @(negedge clk);
        while (ack) @(negedge clk);
        adr = a; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            lat++;
            if (ack) break;
        end
        d = dat_r;
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic wait_irq(input int limit);
        int n = 0;
        while (!irq && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int          lat;
        logic        a1, a2;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if ({dat_r, ack, irq, sclk, mosi, ss_n} !== {32'h0, 5'b00001}) begin
            n_err++; $display("FAIL reset_outputs: got %h/%b%b%b%b%b expected 0/00001", dat_r, ack, irq, sclk, mosi, ss_n);
        end
        @(negedge clk); rst_n = 1'b1;
        wb_read(8'h00, d, lat);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_stat: got %h expected 0", d); end
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL ack_latency: got %0d expected 1", lat); end
        wb_read(8'h04, d, lat);
        n_cmp++; if (d !== 32'h3) begin n_err++; $display("FAIL reset_div: got %h expected 3", d); end
        wb_read(8'h0C, d, lat);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_rx: got %h expected 0", d); end
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL ack_latency_rx: got %0d expected 1", lat); end
        // Hold the strobe for two edges: ACK must pulse once, not stay high.
        @(negedge clk);
        while (ack) @(negedge clk);
        adr = 8'h00; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1; a1 = ack;
        @(posedge clk); #1; a2 = ack;
        cyc = 1'b0; stb = 1'b0;
        n_cmp++; if ({a1, a2} !== 2'b10) begin n_err++; $display("FAIL ack_pulse: got %b expected 10", {a1, a2}); end
    endtask

    task automatic test_div0_loopback();
        logic [31:0] d;
        int          lat, r0, c0;
        loop_en = 1'b1;
        wb_write(8'h00, 32'h1);
        wb_write(8'h04, 32'h0);
        r0 = mon_rises;
        wb_write(8'h08, 32'hA5);
        c0 = mon_cyc;
        wb_read(8'h00, d, lat);
        n_cmp++; if (d !== 32'h101) begin n_err++; $display("FAIL div0_stat_busy: got %h expected 101", d); end
        wait_irq(400);
        n_cmp++; if (mon_cyc - c0 !== 19) begin n_err++; $display("FAIL div0_busy_cycles: got %0d expected 19", mon_cyc - c0); end
        n_cmp++; if (mon_rises - r0 !== 8) begin n_err++; $display("FAIL div0_rises: got %0d expected 8", mon_rises - r0); end
        n_cmp++; if (mon_period !== 2) begin n_err++; $display("FAIL div0_period: got %0d expected 2", mon_period); end
        n_cmp++; if (mon_bits[7:0] !== 8'hA5) begin n_err++; $display("FAIL div0_mosi_bits: got %h expected a5", mon_bits[7:0]); end
        n_cmp++; if ({mosi, ss_n} !== 2'b01) begin n_err++; $display("FAIL div0_idle_pins: got %b expected 01", {mosi, ss_n}); end
        wb_read(8'h00, d, lat);
        n_cmp++; if (d !== 32'h102) begin n_err++; $display("FAIL div0_stat_done: got %h expected 102", d); end
        wb_read(8'h0C, d, lat);
        n_cmp++; if (d !== 32'hA5) begin n_err++; $display("FAIL div0_rx: got %h expected a5", d); end
        wb_read(8'h08, d, lat);
        n_cmp++; if (d !== 32'hA5) begin n_err++; $display("FAIL div0_tx_readback: got %h expected a5", d); end
        loop_en = 1'b0;
    endtask

    task automatic test_div3_irq();
        logic [31:0] d;
        int          lat, c0, s0;
        miso_val = 1'b1;
        wb_write(8'h04, 32'h3);
        s0 = mon_ss_low;
        wb_write(8'h08, 32'h3C);
        c0 = mon_cyc;
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL div3_irq_early: got %b expected 0", irq); end
        wait_irq(400);
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL div3_irq_rise: got %b expected 1", irq); end
        n_cmp++; if (mon_cyc - c0 !== 73) begin n_err++; $display("FAIL div3_busy_cycles: got %0d expected 73", mon_cyc - c0); end
        n_cmp++; if (mon_ss_low - s0 !== 72) begin n_err++; $display("FAIL div3_ss_low: got %0d expected 72", mon_ss_low - s0); end
        n_cmp++; if (mon_period !== 8) begin n_err++; $display("FAIL div3_period: got %0d expected 8", mon_period); end
        n_cmp++; if (mon_bits[7:0] !== 8'h3C) begin n_err++; $display("FAIL div3_mosi_bits: got %h expected 3c", mon_bits[7:0]); end
        wb_read(8'h0C, d, lat);
        n_cmp++; if (d !== 32'hFF) begin n_err++; $display("FAIL div3_rx: got %h expected ff", d); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL div3_irq_clear: got %b expected 0", irq); end
        wb_read(8'h00, d, lat);
        n_cmp++; if (d !== 32'h100) begin n_err++; $display("FAIL div3_stat_after_rx: got %h expected 100", d); end
    endtask

    task automatic test_overrun();
        logic [31:0] d;
        int          lat, r0;
        miso_val = 1'b0;
        r0 = mon_rises;
        wb_write(8'h08, 32'h11);
        wb_write(8'h08, 32'h22);
        wb_read(8'h00, d, lat);
        n_cmp++; if (d !== 32'h105) begin n_err++; $display("FAIL ovr_stat_busy: got %h expected 105", d); end
        wait_irq(400);
        n_cmp++; if (mon_rises - r0 !== 8) begin n_err++; $display("FAIL ovr_rises: got %0d expected 8", mon_rises - r0); end
        n_cmp++; if (mon_bits[7:0] !== 8'h11) begin n_err++; $display("FAIL ovr_mosi_bits: got %h expected 11", mon_bits[7:0]); end
        wb_read(8'h00, d, lat);
        n_cmp++; if (d !== 32'h106) begin n_err++; $display("FAIL ovr_stat_done: got %h expected 106", d); end
        wb_write(8'h00, 32'h5);
        wb_read(8'h00, d, lat);
        n_cmp++; if (d !== 32'h102) begin n_err++; $display("FAIL ovr_clear: got %h expected 102", d); end
        wb_read(8'h0C, d, lat);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL ovr_rx: got %h expected 0", d); end
        wb_read(8'h00, d, lat);
        n_cmp++; if (d !== 32'h100) begin n_err++; $display("FAIL ovr_stat_final: got %h expected 100", d); end
    endtask

    task automatic test_reset_mid_shift();
        logic [31:0] d;
        int          lat;
        wb_write(8'h08, 32'h5A);
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_cmp++; if ({ss_n, sclk} !== 2'b01) begin n_err++; $display("FAIL rst_pre_state: got %b expected 01", {ss_n, sclk}); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({ss_n, sclk, mosi} !== 3'b100) begin n_err++; $display("FAIL rst_pins: got %b expected 100", {ss_n, sclk, mosi}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wb_read(8'h00, d, lat);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL rst_stat: got %h expected 0", d); end
        wb_read(8'h0C, d, lat);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL rst_rx: got %h expected 0", d); end
        wb_read(8'h04, d, lat);
        n_cmp++; if (d !== 32'h3) begin n_err++; $display("FAIL rst_div: got %h expected 3", d); end
    endtask

    task automatic test_div_change();
        logic [31:0] d;
        int          lat, c0, r0;
        wb_write(8'h00, 32'h1);
        wb_write(8'h04, 32'h1);
        wb_write(8'h08, 32'h81);
        c0 = mon_cyc;
        wb_write(8'h04, 32'h7);
        wb_read(8'h04, d, lat);
        n_cmp++; if (d !== 32'h7) begin n_err++; $display("FAIL divchg_readback: got %h expected 7", d); end
        wait_irq(600);
        n_cmp++; if (mon_cyc - c0 !== 37) begin n_err++; $display("FAIL divchg_busy1: got %0d expected 37", mon_cyc - c0); end
        n_cmp++; if (mon_period !== 4) begin n_err++; $display("FAIL divchg_period1: got %0d expected 4", mon_period); end
        wb_read(8'h0C, d, lat);
        r0 = mon_rises;
        wb_write(8'h08, 32'h42);
        c0 = mon_cyc;
        wait_irq(600);
        n_cmp++; if (mon_cyc - c0 !== 145) begin n_err++; $display("FAIL divchg_busy2: got %0d expected 145", mon_cyc - c0); end
        n_cmp++; if (mon_period !== 16) begin n_err++; $display("FAIL divchg_period2: got %0d expected 16", mon_period); end
        n_cmp++; if (mon_rises - r0 !== 8) begin n_err++; $display("FAIL divchg_rises2: got %0d expected 8", mon_rises - r0); end
        n_cmp++; if (mon_bits[7:0] !== 8'h42) begin n_err++; $display("FAIL divchg_mosi_bits: got %h expected 42", mon_bits[7:0]); end
    endtask

    initial begin
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_w = '0;
        loop_en = 1'b0; miso_val = 1'b0;
        test_reset();
        test_div0_loopback();
        test_div3_irq();
        test_overrun();
        test_reset_mid_shift();
        test_div_change();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/wb_spi_master_ctrl.md
Name: wb_spi_master_ctrl

Overview:
- Wishbone classic slave that sequences a single-byte SPI master transfer engine.
- Software programs a clock divisor, writes a TX byte and polls status or waits for an interrupt, then reads the RX byte.
- Sits between the top-level Wishbone bus and the external SPI pins.
- Generates its own SCLK from CLK_I through an internal programmable half-period counter.

Parameters:
- DATA_W, 8: SPI frame width in bits. TX and RX register width.
- DIV_W, 8: width of the divisor register.
- DIV_RST, 8'd3: reset value of the divisor.

Ports:
- CLK_I  in  1  system clock. All logic is on the rising edge.
- RST_I  in  1  asynchronous, active-low reset.
- ADR_I  in  8  byte address. Only ADR_I[3:2] is decoded.
- CYC_I  in  1  bus cycle valid.
- STB_I  in  1  slave select strobe.
- WE_I  in  1  1=write, 0=read.
- DAT_I  in  32  write data.
- DAT_O  out  32  read data.
- ACK_O  out  1  cycle acknowledge.
- IRQ_O  out  1  transfer-done interrupt.
- SCLK_O  out  1  SPI clock (CPOL=0).
- MOSI_O  out  1  SPI data out.
- MISO_I  in  1  SPI data in.
- SS_N_O  out  1  slave select, active low.

Behaviour:
- Reset values: DAT_O=0, ACK_O=0, IRQ_O=0, SCLK_O=0, MOSI_O=0, SS_N_O=1. DIV=DIV_RST, all other registers and flags 0. FSM state is IDLE.
- Register map (ADR_I[3:2]):
  - 0 CTRL/STAT: write bit0=IE, bit1=1 clears DONE, bit2=1 clears OVR. Read returns {29'b0, OVR, DONE, BUSY}, with IE readable at bit8.
  - 1 DIV: read/write, lower DIV_W bits.
  - 2 TXDATA: write starts a transfer. Reads return the last written value.
  - 3 RXDATA: read-only. A read clears DONE.
- Bus handshake:
  - ACK_O <= CYC_I & STB_I & ~ACK_O, registered, so ACK_O is high one cycle after the request and is never high two consecutive cycles.
  - Register writes and read-side-effects take effect on the cycle ACK_O rises.
  - DAT_O is valid while ACK_O=1.
- Start rules:
  - A TXDATA write while BUSY=0 loads the shift register, sets BUSY and leaves IDLE on the next cycle.
  - A TXDATA write while BUSY=1 is ignored (shift register untouched) and sets OVR.
- Half-period timing: the half-period counter counts DIV+1 CLK_I cycles, so the SCLK period is 2*(DIV+1). The counter reloads at every phase boundary.
- FSM states:
  - IDLE.
  - SETUP: SS_N_O=0, MOSI_O=MSB, SCLK_O=0; lasts one half-period.
  - SHIFT: 2*DATA_W half-periods. Each rising SCLK edge samples MISO_I into the RX shift LSB. Each falling edge shifts and drives the next MOSI bit, MSB first (mode 0).
  - HOLD: SCLK_O=0, SS_N_O=0; lasts one half-period.
  - DONE: one cycle; SS_N_O=1, RXDATA<=shift register, DONE=1, BUSY=0; then IDLE.
- BUSY is high for exactly (2*DATA_W+2)*(DIV+1)+1 cycles after the write ACK.
- IRQ_O = DONE & IE (combinational from registered flags).
- DIV writes during BUSY update the register but take effect only at the next transfer. The divisor is latched on entry to SETUP.
- Simultaneous events:
  - DONE-set in the DONE state has priority over a clear in the same cycle.
  - OVR-set has priority over an OVR clear.
- MOSI_O returns to 0 in IDLE.
- Reset mid-transfer: immediate SS_N_O=1, SCLK_O=0, all state to reset values, no RX update.
- DIV=0 is legal and gives SCLK = CLK_I/2.

Test Plan:
- Reset, then read each address -> ACK_O high exactly one cycle after STB_I, single-cycle pulse. Data: STAT=0, DIV=3, RX=0.
- DIV=0, MOSI looped to MISO, write TX=0xA5 -> SCLK period 2 cycles, 8 rising edges, MOSI bit stream 1,0,1,0,0,1,0,1, BUSY high 19 cycles, RX=0xA5, DONE=1.
- DIV=3, IE=1, MISO held 1, TX=0x3C -> SCLK period 8 cycles, SS_N low 72 cycles, IRQ_O rises at DONE, RX=0xFF. Reading RX clears DONE and drops IRQ_O.
- Write TX=0x11 then TX=0x22 while BUSY -> OVR=1, MOSI transmits 0x11. Writing CTRL bit2 clears OVR.
- Assert RST_I low midway through SHIFT -> SS_N_O=1 and SCLK_O=0 in the same cycle. After release, STAT=0 and RX unchanged at 0.
- Write DIV=7 during a DIV=1 transfer -> current transfer keeps a 4-cycle period, next transfer uses a 16-cycle period.
